// File: rtl/spi_reg_controller_if.sv
// Request/response bundle between a register-access client (master) and the SPI controller (slave).
interface spi_reg_controller_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       done;
    logic [7:0] rd_data;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, done, rd_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, done, rd_data
    );
endinterface

// File: rtl/spi_reg_controller.sv
// SPI mode-0 initiator: one {rw,addr,data} 16-bit frame per accepted request, done pulse when nCS rises;
// ready only in IDLE (no queueing). SPI_CTRL_READBACK_EN adds CIPO capture into rd_data for read frames.
module spi_reg_controller #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int IDLE_GAP = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    spi_reg_controller_if.slave     bus,
    output logic                    o_sclk,
    output logic                    o_ncs,
    output logic                    o_copi,
    input  logic                    i_cipo
);
    localparam int PH_W  = $clog2(CLK_DIV) + 1;
    localparam int T_MAX = (CS_SETUP > CS_HOLD)
                         ? ((CS_SETUP > IDLE_GAP) ? CS_SETUP : IDLE_GAP)
                         : ((CS_HOLD  > IDLE_GAP) ? CS_HOLD  : IDLE_GAP);
    localparam int TMR_W = $clog2(T_MAX) + 1;

    localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_ONE     = PH_W'(1);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
    localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(CS_SETUP - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(CS_HOLD - 1);
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t            r_state;
    logic [PH_W-1:0]   r_phase;
    logic [4:0]        r_bit;
    logic [TMR_W-1:0]  r_tmr;
    logic [15:0]       r_shift;
    logic              r_sclk;
    logic              r_ncs;
    logic              r_copi;
    logic              r_done;
    logic              w_accept;

`ifdef SPI_CTRL_READBACK_EN
    logic              r_rw;
    logic [7:0]        r_cap;
    logic [7:0]        r_rd_data;
    assign bus.rd_data = r_rd_data;
`else
    logic              w_unused_cipo;
    assign w_unused_cipo = i_cipo;
    assign bus.rd_data   = 8'h00;
`endif

    assign w_accept      = bus.req_valid && (r_state == ST_IDLE);
    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.done      = r_done;
    assign o_sclk        = r_sclk;
    assign o_ncs         = r_ncs;
    assign o_copi        = r_copi;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_phase   <= '0;
            r_bit     <= '0;
            r_tmr     <= '0;
            r_shift   <= '0;
            r_sclk    <= 1'b0;
            r_ncs     <= 1'b1;
            r_copi    <= 1'b0;
            r_done    <= 1'b0;
`ifdef SPI_CTRL_READBACK_EN
            r_rw      <= 1'b0;
            r_cap     <= '0;
            r_rd_data <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_SETUP;
                        r_ncs   <= 1'b0;
                        r_copi  <= bus.req_write;
                        // Bit 15 goes straight to copi; the rest queue up MSB-first.
                        r_shift <= {bus.req_addr, bus.req_wdata, 1'b0};
                        r_tmr   <= '0;
`ifdef SPI_CTRL_READBACK_EN
                        r_rw    <= bus.req_write;
`endif
                    end
                end
                ST_SETUP: begin
                    if (r_tmr == SETUP_LAST) begin
                        r_state <= ST_SHIFT;
                        r_phase <= '0;
                        r_bit   <= '0;
                    end else begin
                        r_tmr <= r_tmr + TMR_ONE;
                    end
                end
                ST_SHIFT: begin
                    if (r_phase != PH_LAST) begin
                        r_phase <= r_phase + PH_ONE;
                    end else begin
                        r_phase <= '0;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
`ifdef SPI_CTRL_READBACK_EN
                            r_cap  <= {r_cap[6:0], i_cipo};
`endif
                        end else begin
                            // Falling edge: copi only changes here, so it is stable across every high phase.
                            r_sclk  <= 1'b0;
                            r_copi  <= r_shift[15];
                            r_shift <= {r_shift[14:0], 1'b0};
                            r_bit   <= r_bit + 5'd1;
                            if (r_bit == 5'd15) begin
                                r_state <= ST_HOLD;
                                r_tmr   <= '0;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_tmr == HOLD_LAST) begin
                        r_ncs   <= 1'b1;
                        r_done  <= 1'b1;
                        r_copi  <= 1'b0;
                        r_tmr   <= '0;
                        r_state <= (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;
`ifdef SPI_CTRL_READBACK_EN
                        if (!r_rw) begin
                            r_rd_data <= r_cap;
                        end
`endif
                    end else begin
                        r_tmr <= r_tmr + TMR_ONE;
                    end
                end
                ST_GAP: begin
                    if (r_tmr == GAP_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_tmr <= r_tmr + TMR_ONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_reg_controller.sv
// Directed bench: default-parameter controller plus a fast (1/1/1/0) instance, observed by an SPI pin monitor.
module tb_spi_reg_controller;
`ifdef SPI_CTRL_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic sclk_a, ncs_a, copi_a, cipo_a;
    logic sclk_f, ncs_f, copi_f, cipo_f;
    logic [7:0] cipo_pat;

    always #5 clk = ~clk;

    spi_reg_controller_if bus_a ();
    spi_reg_controller_if bus_f ();

    spi_reg_controller u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_a.slave),
        .o_sclk  (sclk_a),
        .o_ncs   (ncs_a),
        .o_copi  (copi_a),
        .i_cipo  (cipo_a)
    );

    spi_reg_controller #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .IDLE_GAP(0)) u_dut_fast (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_f.slave),
        .o_sclk  (sclk_f),
        .o_ncs   (ncs_f),
        .o_copi  (copi_f),
        .i_cipo  (cipo_f)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Pin monitor state, index 0 = default instance, 1 = fast instance.
    logic [1:0]  m_sclk, m_ncs, m_copi, m_done;
    logic        prev_sclk [2] = '{1'b0, 1'b0};
    logic        prev_ncs  [2] = '{1'b1, 1'b1};
    int          mon_frames[2] = '{0, 0};
    int          mon_dones [2] = '{0, 0};
    int          mon_low   [2] = '{0, 0};
    int          mon_lowlast[2] = '{0, 0};
    int          mon_high  [2] = '{0, 0};
    int          mon_gap   [2] = '{0, 0};
    int          mon_rises [2] = '{0, 0};
    int          mon_first [2] = '{0, 0};
    int          mon_per   [2] = '{0, 0};
    int          mon_lastrise[2] = '{0, 0};
    logic [15:0] mon_shift [2] = '{16'h0, 16'h0};
    logic [15:0] mon_frame [2] = '{16'h0, 16'h0};

    assign m_sclk = {sclk_f, sclk_a};
    assign m_ncs  = {ncs_f, ncs_a};
    assign m_copi = {copi_f, copi_a};
    assign m_done = {bus_f.done, bus_a.done};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (m_done[d]) mon_dones[d]++;
            if (!m_ncs[d]) begin
                if (prev_ncs[d]) begin
                    mon_gap[d]   = mon_high[d];
                    mon_low[d]   = 0;
                    mon_rises[d] = 0;
                    mon_shift[d] = 16'h0;
                end
                mon_low[d]++;
                if (m_sclk[d] && !prev_sclk[d]) begin
                    mon_shift[d] = {mon_shift[d][14:0], m_copi[d]};
                    if (mon_rises[d] == 0) mon_first[d] = mon_low[d] - 1;
                    else                   mon_per[d]   = mon_low[d] - mon_lastrise[d];
                    mon_lastrise[d] = mon_low[d];
                    mon_rises[d]++;
                end
            end else begin
                if (!prev_ncs[d]) begin
                    mon_frame[d]   = mon_shift[d];
                    mon_lowlast[d] = mon_low[d];
                    mon_frames[d]++;
                    mon_high[d]    = 0;
                end
                mon_high[d]++;
            end
            prev_ncs[d]  = m_ncs[d];
            prev_sclk[d] = m_sclk[d];
        end
        // Peripheral model: present the read byte during frame bits 7:0, ahead of each SCLK rise.
        if (!ncs_a && !sclk_a)
            cipo_a = (mon_rises[0] >= 8 && mon_rises[0] < 16) ? cipo_pat[3'(15 - mon_rises[0])] : 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_frames(input int d, input int target, input string tag);
        int n = 0;
        while (mon_frames[d] < target && n < 1000) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 32'(mon_frames[d] >= target), 32'd1);
    endtask

    task automatic wait_ncs_low(input int d, input string tag);
        int n = 0;
        while (m_ncs[d] && n < 1000) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 32'(m_ncs[d]), 32'd0);
    endtask

    task automatic send_a(input logic w, input logic [6:0] a, input logic [7:0] d);
        int n = 0;
        while (!bus_a.req_ready && n < 1000) begin
            tick();
            n++;
        end
        bus_a.req_valid = 1'b1;
        bus_a.req_write = w;
        bus_a.req_addr  = a;
        bus_a.req_wdata = d;
        tick();
        bus_a.req_valid = 1'b0;
        bus_a.req_addr  = ~a;
        bus_a.req_wdata = ~d;
    endtask

    initial begin
        int f, d0;
        rst_n = 1'b0;
        cipo_a = 1'b0;
        cipo_f = 1'b0;
        cipo_pat = 8'h00;
        bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
        bus_f.req_valid = 1'b0; bus_f.req_write = 1'b0; bus_f.req_addr = '0; bus_f.req_wdata = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("rst_ncs",   ncs_a,         1);
        check("rst_sclk",  sclk_a,        0);
        check("rst_copi",  copi_a,        0);
        check("rst_done",  bus_a.done,    0);
        check("rst_rdata", bus_a.rd_data, 8'h00);
        check("rst_ready", bus_a.req_ready, 1);

        // Single write with default timing.
        f = mon_frames[0];
        d0 = mon_dones[0];
        send_a(1'b1, 7'h00, 8'hF0);
        check("t1_ncs_fall", ncs_a, 0);
        wait_frames(0, f + 1, "t1");
        check("t1_frame",   mon_frame[0],   16'h80F0);
        check("t1_ncs_low", mon_lowlast[0], 132);
        check("t1_first",   mon_first[0],   6);
        check("t1_period",  mon_per[0],     8);
        check("t1_done",    bus_a.done,     1);
        check("t1_rdy0",    bus_a.req_ready, 0);
        tick();
        check("t1_rdy1",    bus_a.req_ready, 0);
        check("t1_done_off", bus_a.done,    0);
        tick();
        check("t1_rdy2",    bus_a.req_ready, 1);
        check("t1_ndone",   mon_dones[0] - d0, 1);

        // Back-to-back with valid held and inputs changed mid-frame.
        f = mon_frames[0];
        bus_a.req_valid = 1'b1; bus_a.req_write = 1'b1;
        bus_a.req_addr = 7'h01; bus_a.req_wdata = 8'h0F;
        tick();
        bus_a.req_addr = 7'h04; bus_a.req_wdata = 8'h80;
        wait_frames(0, f + 1, "t2a");
        check("t2_frame0", mon_frame[0], 16'h810F);
        wait_ncs_low(0, "t2_refall");
        bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0;
        bus_a.req_addr = 7'h7F; bus_a.req_wdata = 8'hFF;
        check("t2_gap", mon_gap[0], 3);
        wait_frames(0, f + 2, "t2b");
        check("t2_frame1", mon_frame[0], 16'h8480);

        // Read with 0xA5 on cipo, then a write must not disturb rd_data.
        cipo_pat = 8'hA5;
        f = mon_frames[0];
        send_a(1'b0, 7'h03, 8'h00);
        wait_frames(0, f + 1, "t3r");
        check("t3_frame",  mon_frame[0],  16'h0300);
        check("t3_rdata",  bus_a.rd_data, RB ? 8'hA5 : 8'h00);
        send_a(1'b1, 7'h05, 8'h11);
        wait_frames(0, f + 2, "t3w");
        check("t3_wframe", mon_frame[0],  16'h8511);
        check("t3_keep",   bus_a.rd_data, RB ? 8'hA5 : 8'h00);

        // Read with cipo held high.
        cipo_pat = 8'hFF;
        f = mon_frames[0];
        send_a(1'b0, 7'h03, 8'h3C);
        wait_frames(0, f + 1, "t4");
        check("t4_frame", mon_frame[0],  16'h033C);
        check("t4_rdata", bus_a.rd_data, RB ? 8'hFF : 8'h00);

        // Reset after the 5th SCLK rise abandons the frame.
        send_a(1'b1, 7'h06, 8'h99);
        begin
            int n = 0;
            while (!(!ncs_a && mon_rises[0] >= 5) && n < 1000) begin
                tick();
                n++;
            end
            check("t5_rise_timeout", 32'(mon_rises[0]), 5);
        end
        d0 = mon_dones[0];
        rst_n = 1'b0;
        tick();
        check("t5_ncs",   ncs_a,           1);
        check("t5_sclk",  sclk_a,          0);
        check("t5_copi",  copi_a,          0);
        check("t5_ready", bus_a.req_ready, 1);
        check("t5_done",  bus_a.done,      0);
        check("t5_rdata", bus_a.rd_data,   8'h00);
        rst_n = 1'b1;
        tick();
        check("t5_nodone", mon_dones[0] - d0, 0);
        f = mon_frames[0];
        send_a(1'b1, 7'h02, 8'h55);
        wait_frames(0, f + 1, "t5");
        check("t5_frame", mon_frame[0], 16'h8255);

        // Fast instance: minimum timing, back-to-back.
        f = mon_frames[1];
        bus_f.req_valid = 1'b1; bus_f.req_write = 1'b1;
        bus_f.req_addr = 7'h0A; bus_f.req_wdata = 8'h3C;
        tick();
        bus_f.req_write = 1'b0; bus_f.req_addr = 7'h01; bus_f.req_wdata = 8'h55;
        wait_frames(1, f + 1, "t6a");
        check("t6_frame0", mon_frame[1],   16'h8A3C);
        check("t6_low",    mon_lowlast[1], 34);
        check("t6_period", mon_per[1],     2);
        check("t6_first",  mon_first[1],   2);
        wait_ncs_low(1, "t6_refall");
        bus_f.req_valid = 1'b0;
        check("t6_gap", mon_gap[1], 1);
        wait_frames(1, f + 2, "t6b");
        check("t6_frame1", mon_frame[1], 16'h0155);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spi_reg_controller.md
# spi_reg_controller

SPI controller (initiator) that issues 16-bit register-access frames to the onboarding SPI peripheral inside `tt_um_uwasic_onboarding_benjamin_dong`. It accepts one request at a time over a valid/ready handshake. It serialises `{rw, addr[6:0], data[7:0]}` MSB-first in SPI mode 0 and pulses `done` at frame end. It sits in the bench/harness subsystem and in future on-chip bring-up logic, driving the peripheral's SCLK/nCS/COPI pins.

## Interface
Parameters:
- `CLK_DIV`, 4: clk cycles per SCLK half-period (≥1).
- `CS_SETUP`, 2: clk cycles from nCS fall to the first SCLK rise phase start (≥1).
- `CS_HOLD`, 2: clk cycles from the last SCLK fall to nCS rise (≥1).
- `IDLE_GAP`, 2: clk cycles nCS stays high after a frame before `req_ready` reasserts (≥0).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller idle and able to accept a request.
- `req_write` in 1: 1 = write, 0 = read; becomes frame bit 15.
- `req_addr` in 7: register address; frame bits 14:8.
- `req_wdata` in 8: write data; frame bits 7:0 (sent as-is for reads).
- `sclk` out 1: SPI clock, idle low (CPOL=0).
- `ncs` out 1: chip select, active low.
- `copi` out 1: controller-out data.
- `cipo` in 1: controller-in data; used only with readback.
- `done` out 1: one-cycle pulse at frame completion.
- `rd_data` out 8: last captured read byte.

## Operation
- Reset values: `sclk`=0, `ncs`=1, `copi`=0, `done`=0, `rd_data`=0x00, `req_ready`=1 (state IDLE). All outputs are registered except `req_ready`, which is `(state==IDLE)`.
- States:
  - IDLE → SETUP on `req_valid && req_ready`. Latch the 16-bit frame, drive `ncs`=0 and `copi`=bit15.
  - SETUP (CS_SETUP cycles) → SHIFT.
  - SHIFT: per bit, run a low phase of CLK_DIV cycles, then a high phase of CLK_DIV cycles. At the end of each high phase, `sclk` falls and `copi` advances to the next bit. After 16 bits → HOLD with `sclk`=0.
  - HOLD (CS_HOLD cycles) → GAP. On entry, set `ncs`=1, `done`=1 for one cycle and `copi`=0.
  - GAP (IDLE_GAP cycles; 0 means straight through) → IDLE.
- `copi` is stable for the full high phase of every bit (peripheral samples on SCLK rise).
- The bit counter is 5 bits and the phase counter is `$clog2(CLK_DIV)+1` bits. No wrap occurs inside a frame.
- While not in IDLE, `req_valid` is ignored and request inputs may change freely; only latched values are sent.
- `req_valid` held high continuously yields back-to-back frames separated by exactly IDLE_GAP+1 cycles of `ncs` high.
- If `rst_n` goes low mid-frame, all outputs take their reset values on the next edge. The frame is abandoned and `done` does not pulse.

## Timing
- Request accepted at edge N; `ncs` falls at edge N+1.
- First `sclk` rise occurs at edge N+1+CS_SETUP+CLK_DIV.
- `ncs` low duration = CS_SETUP + 32·CLK_DIV + CS_HOLD cycles (132 with defaults).
- `done` is asserted in the same cycle `ncs` returns high.
- `req_ready` rises IDLE_GAP cycles after `done`.
- Accept-to-accept minimum = 1 + CS_SETUP + 32·CLK_DIV + CS_HOLD + IDLE_GAP cycles (135 with defaults).

## Configuration
- `SPI_CTRL_READBACK_EN` defined:
  - `cipo` is registered on the clk cycle `sclk` rises, shifted into an 8-bit capture register MSB-first.
  - For read frames (bit15=0), `rd_data` loads the last 8 captured bits (frame bits 7:0 window) in the `done` cycle.
  - Write frames leave `rd_data` unchanged.
- Undefined: no capture logic, `cipo` is ignored and `rd_data` is constant 0x00. Read frames are still transmitted identically.

## Test plan
- Write addr 0x00, data 0xF0, defaults → a model sampling on `sclk` rise captures 0x80F0. `ncs` is low for 132 cycles. `done` pulses once, then `req_ready` is 1 two cycles later.
- `req_valid` held high with writes 0x01←0x0F then 0x04←0x80 → frames 0x810F and 0x8480. `ncs` is high for exactly 3 cycles between them. Inputs changed mid-frame do not alter the bits sent.
- Readback build, read addr 0x03, model drives 0xA5 on `cipo` during bits 7:0 → `rd_data`=0xA5 in the `done` cycle. A following write leaves `rd_data` at 0xA5.
- Reset asserted after the 5th `sclk` rise → next edge shows `ncs`=1, `sclk`=0, `copi`=0, `req_ready`=1 and no `done`. A subsequent write 0x02←0x55 frames correctly as 0x8255.
- CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, IDLE_GAP=0 → `sclk` period is 2 clk and `ncs` is low for 34 cycles. Back-to-back frames have `ncs` high for 1 cycle.
- Build without the macro, read with `cipo`=1 → `rd_data` stays 0x00 and the frame is 0x03xx as latched.
